// File: rtl/elevator_pkg.sv
// elevator_pkg: shared widths, timing constants, direction codes and dispatcher state encoding
package elevator_pkg;
    localparam int FLOOR_W        = 3;
    localparam int NUM_FLOORS     = 1 << FLOOR_W;
    localparam int DEPART_TIMEOUT = 4;
    localparam int DWELL_CYCLES   = 4;
    localparam int CNT_W          = 3;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;
    typedef enum logic [2:0] {IDLE, SELECT, WAIT_DEPART, WAIT_ARRIVE, DWELL} state_e;
endpackage

// File: rtl/elevator_scan_select.sv
// elevator_scan_select: SCAN target choice from the pending bitmap, current floor and direction
module elevator_scan_select
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  dir_up,
    output logic                  target_valid,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  next_dir
);
    logic               up_v, dn_v;
    logic [FLOOR_W-1:0] up_f, dn_f;

    // ascending scan: first hit above is the lowest, last hit below is the highest
    always_comb begin
        up_v = 1'b0;
        dn_v = 1'b0;
        up_f = '0;
        dn_f = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && FLOOR_W'(i) > current_floor && !up_v) begin
                up_v = 1'b1;
                up_f = FLOOR_W'(i);
            end
            if (pending[i] && FLOOR_W'(i) < current_floor) begin
                dn_v = 1'b1;
                dn_f = FLOOR_W'(i);
            end
        end
    end

    assign target_valid = up_v || dn_v;
    assign target_floor = (dir_up && up_v) ? up_f : dn_v ? dn_f : up_f;
    assign next_dir     = !target_valid ? dir_up : (dir_up && up_v) ? DIR_UP : dn_v ? DIR_DN : DIR_UP;
endmodule

// File: rtl/elevator_call_dispatcher.sv
// elevator_call_dispatcher: collects calls, issues SCAN targets, retires served floors
// Optional door dwell after arrival when ELEV_DOOR_DWELL_EN is defined.
module elevator_call_dispatcher
    import elevator_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  moving,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  busy,
    output logic                  served,
    output logic [FLOOR_W-1:0]    served_floor
);
    state_e                state_q, state_d;
    logic [FLOOR_W-1:0]    req_floor_q, req_floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d, call_set, clr;
    logic                  dir_up_q, dir_up_d;
    logic                  served_q, served_d;
    logic [FLOOR_W-1:0]    served_floor_q, served_floor_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tgt_valid, tgt_dir;
    logic [FLOOR_W-1:0]    tgt_floor;

    elevator_scan_select u_scan (
        .pending      (pending_q),
        .current_floor(current_floor),
        .dir_up       (dir_up_q),
        .target_valid (tgt_valid),
        .target_floor (tgt_floor),
        .next_dir     (tgt_dir)
    );

    always_comb begin
        state_d        = state_q;
        req_floor_d    = req_floor_q;
        dir_up_d       = dir_up_q;
        cnt_d          = cnt_q;
        served_d       = 1'b0;
        served_floor_d = served_floor_q;
        clr            = '0;
        call_set       = '0;
        if (call_valid) call_set[call_floor] = 1'b1;
        case (state_q)
            IDLE: state_d = (pending_q != '0 || call_valid) ? SELECT : IDLE;
            SELECT: begin
                if (pending_q[current_floor]) begin
                    clr[current_floor] = 1'b1;
                    served_d           = 1'b1;
                    served_floor_d     = current_floor;
                    state_d            = ((pending_q & ~clr) != '0) ? SELECT : IDLE;
                end else if (tgt_valid) begin
                    req_floor_d = tgt_floor;
                    dir_up_d    = tgt_dir;
                    cnt_d       = '0;
                    state_d     = WAIT_DEPART;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_DEPART: begin
                if (moving) state_d = WAIT_ARRIVE;
                else if (cnt_q == CNT_W'(DEPART_TIMEOUT - 1)) state_d = SELECT;
                else cnt_d = cnt_q + 1'b1;
            end
            WAIT_ARRIVE: begin
                if (!moving && current_floor == req_floor_q) begin
                    clr[req_floor_q] = 1'b1;
                    served_d         = 1'b1;
                    served_floor_d   = req_floor_q;
`ifdef ELEV_DOOR_DWELL_EN
                    cnt_d            = '0;
                    state_d          = DWELL;
`else
                    state_d          = IDLE;
`endif
                end else if (!moving) begin
                    state_d = SELECT;
                end
            end
`ifdef ELEV_DOOR_DWELL_EN
            DWELL: begin
                if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) state_d = SELECT;
                else cnt_d = cnt_q + 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
        // a call landing on the floor retired this cycle is absorbed
        pending_d = (pending_q | call_set) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            req_floor_q    <= '0;
            pending_q      <= '0;
            dir_up_q       <= DIR_UP;
            served_q       <= 1'b0;
            served_floor_q <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            req_floor_q    <= req_floor_d;
            pending_q      <= pending_d;
            dir_up_q       <= dir_up_d;
            served_q       <= served_d;
            served_floor_q <= served_floor_d;
            cnt_q          <= cnt_d;
        end
    end

    assign req_floor    = req_floor_q;
    assign pending      = pending_q;
    assign dir_up       = dir_up_q;
    assign busy         = state_q != IDLE;
    assign served       = served_q;
    assign served_floor = served_floor_q;
endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// tb_elevator_call_dispatcher: directed checks of capture, SCAN ordering, retire, timeout and reset
module tb_elevator_call_dispatcher;
    import elevator_pkg::*;
    logic                  clk = 1'b0;
    logic                  reset, call_valid, moving;
    logic [FLOOR_W-1:0]    call_floor, current_floor;
    logic [FLOOR_W-1:0]    req_floor, served_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up, busy, served;
    int                    checks = 0;
    int                    errors = 0;

    elevator_call_dispatcher dut (
        .clk          (clk),
        .reset        (reset),
        .call_valid   (call_valid),
        .call_floor   (call_floor),
        .current_floor(current_floor),
        .moving       (moving),
        .req_floor    (req_floor),
        .pending      (pending),
        .dir_up       (dir_up),
        .busy         (busy),
        .served       (served),
        .served_floor (served_floor)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic press(input int f);
        call_valid = 1'b1;
        call_floor = FLOOR_W'(f);
        tick();
        call_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; call_valid = 1'b0; call_floor = '0; current_floor = '0; moving = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_req", 32'(req_floor), 0);
        check("rst_pend", 32'(pending), 0);
        check("rst_dir", 32'(dir_up), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_served", 32'(served), 0);
        check("rst_sf", 32'(served_floor), 0);

        press(5);
        check("t1_pend", 32'(pending), 32'h20);
        check("t1_busy", 32'(busy), 1);
        check("t1_req_early", 32'(req_floor), 0);
        tick();
        check("t1_req", 32'(req_floor), 5);
        check("t1_dir", 32'(dir_up), 1);
        moving = 1'b1; tick();
        current_floor = 5; tick();
        moving = 1'b0; tick();
        check("t1_served", 32'(served), 1);
        check("t1_sf", 32'(served_floor), 5);
        check("t1_pend_clr", 32'(pending), 0);
        check("t1_idle", 32'(busy), 0);
        tick();
        check("t1_pulse", 32'(served), 0);

        current_floor = 2;
        press(2);
        call_valid = 1'b1; call_floor = 2;
        tick();
        call_valid = 1'b0;
        check("t2_served", 32'(served), 1);
        check("t2_sf", 32'(served_floor), 2);
        check("t2_pend", 32'(pending), 0);
        check("t2_req_hold", 32'(req_floor), 5);
        check("t2_idle", 32'(busy), 0);

        current_floor = 3;
        press(6);
        tick();
        check("t3_req6", 32'(req_floor), 6);
        check("t3_dir6", 32'(dir_up), 1);
        moving = 1'b1; tick();
        press(1);
        press(7);
        check("t3_inflight", 32'(req_floor), 6);
        check("t3_pend", 32'(pending), 32'hc2);
        current_floor = 6; moving = 1'b0; tick();
        check("t3_sf6", 32'(served_floor), 6);
        check("t3_pend6", 32'(pending), 32'h82);
        tick(); tick();
        check("t3_req7", 32'(req_floor), 7);
        check("t3_dir7", 32'(dir_up), 1);
        moving = 1'b1; tick();
        current_floor = 7; moving = 1'b0; tick();
        check("t3_sf7", 32'(served_floor), 7);
        check("t3_pend7", 32'(pending), 32'h02);
        tick(); tick();
        check("t3_req1", 32'(req_floor), 1);
        check("t3_dir1", 32'(dir_up), 0);

        moving = 1'b1; tick();
        press(3);
        current_floor = 1; moving = 1'b0; tick();
        check("t4_sf1", 32'(served_floor), 1);
        check("t4_pend", 32'(pending), 32'h08);
        tick(); tick();
        check("t4_req3", 32'(req_floor), 3);
        check("t4_dir_rev", 32'(dir_up), 1);
        moving = 1'b1; tick();
        current_floor = 4; moving = 1'b0; tick();
        check("t4_over_srv", 32'(served), 0);
        check("t4_over_pend", 32'(pending), 32'h08);
        tick();
        check("t4_reissue", 32'(req_floor), 3);
        check("t4_dir_dn", 32'(dir_up), 0);

        current_floor = 2;
        repeat (4) tick();
        check("to_hold_dir", 32'(dir_up), 0);
        tick();
        check("to_reselect_dir", 32'(dir_up), 1);
        check("to_req", 32'(req_floor), 3);
        check("to_busy", 32'(busy), 1);

        reset = 1'b1; tick(); reset = 1'b0;
        current_floor = 0;
        press(5);
        press(7);
        moving = 1'b1; tick();
        check("t5_pend", 32'(pending), 32'ha0);
        check("t5_req", 32'(req_floor), 5);
        reset = 1'b1; current_floor = 5; moving = 1'b0; tick();
        reset = 1'b0;
        check("t5_pend_rst", 32'(pending), 0);
        check("t5_req_rst", 32'(req_floor), 0);
        check("t5_busy_rst", 32'(busy), 0);
        check("t5_srv_rst", 32'(served), 0);
        tick();
        check("t5_srv_after", 32'(served), 0);
        check("t5_busy_after", 32'(busy), 0);

        current_floor = 0;
        press(2);
        press(4);
        check("t6_req2", 32'(req_floor), 2);
        moving = 1'b1; tick();
        current_floor = 2; moving = 1'b0; tick();
        check("t6_sf2", 32'(served_floor), 2);
`ifdef ELEV_DOOR_DWELL_EN
        check("t6_dwell_busy", 32'(busy), 1);
        repeat (4) tick();
        check("t6_dwell_req", 32'(req_floor), 2);
        check("t6_dwell_busy_end", 32'(busy), 1);
        tick();
        check("t6_req4", 32'(req_floor), 4);
`else
        check("t6_idle", 32'(busy), 0);
        tick(); tick();
        check("t6_req4", 32'(req_floor), 4);
        check("t6_dir4", 32'(dir_up), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/elevator_call_dispatcher.md
Name: elevator_call_dispatcher

Overview:
Request side of the elevator controller's req_floor / current_floor / moving interface. Collects hall and car button presses into a pending-floor bitmap. Picks the next target with SCAN (keep direction, reverse when nothing is left ahead) and drives req_floor to the controller. Tracks departure and arrival so each served floor is retired exactly once.

Parameters:
FLOOR_W, 3, floor index width; fixed to match controller req_floor/current_floor
NUM_FLOORS, 8, 2**FLOOR_W, size of the pending bitmap
DEPART_TIMEOUT, 4, cycles to wait for moving=1 after issuing a target before re-selecting
DWELL_CYCLES, 4, door dwell after arrival; used only with ELEV_DOOR_DWELL_EN

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
call_valid  input  1  button press strobe, one floor per cycle, always accepted
call_floor  input  FLOOR_W  floor of the press
current_floor  input  FLOOR_W  from controller
moving  input  1  from controller
req_floor  output  FLOOR_W  target floor to controller (registered)
pending  output  NUM_FLOORS  outstanding-call bitmap (registered)
dir_up  output  1  current SCAN direction, 1 = up
busy  output  1  state != IDLE
served  output  1  one-cycle pulse, floor retired
served_floor  output  FLOOR_W  floor retired, valid with served

Behaviour:
- One clock. Reset is synchronous and active-high. All state is on posedge clk.
- Reset values:
  - req_floor=0, pending=0, dir_up=1, busy=0, served=0, served_floor=0, state=IDLE, counters=0.
  - Reset mid-operation drops all pending calls. The controller is reset separately.
- Call capture: on call_valid, pending[call_floor] is set at the next edge. Duplicate presses OR in.
- Same-cycle collision: a call for the floor being retired in that cycle is absorbed (clear wins).
- State machine IDLE, SELECT, WAIT_DEPART, WAIT_ARRIVE (+DWELL):
  - IDLE: if pending!=0 or call_valid, go to SELECT.
  - SELECT, pending bit at current_floor set:
    - Clear that bit, pulse served with served_floor=current_floor.
    - req_floor is not changed; the controller will not move for an equal floor.
    - Stay in SELECT if other bits remain, else go to IDLE.
  - SELECT, otherwise, compute the target:
    - up_cand = lowest pending floor > current_floor; dn_cand = highest pending floor < current_floor.
    - If dir_up and up_cand exists, take up_cand.
    - Else if dn_cand exists, take dn_cand and set dir_up=0.
    - Else if up_cand exists, take up_cand and set dir_up=1.
    - Register req_floor and go to WAIT_DEPART.
    - If pending is empty, go to IDLE.
  - WAIT_DEPART:
    - moving=1 goes to WAIT_ARRIVE.
    - Otherwise count; at DEPART_TIMEOUT go to SELECT (re-evaluate, bit kept).
  - WAIT_ARRIVE: req_floor is held constant. On moving=0:
    - If current_floor==req_floor: clear pending[req_floor], pulse served, go to IDLE (or DWELL).
    - Else (overshoot or undershoot): keep the bit, go to SELECT.
  - New calls are accepted in every state. They affect only the next SELECT; an in-flight target is never changed.
- Latency: call_valid at edge t (IDLE) sets pending and enters SELECT at t+1. req_floor is updated at t+2.
- Width: candidate search is an 8-entry priority scan. No arithmetic wrap; floors 0 and 7 are the end stops.

Optional Feature:
ELEV_DOOR_DWELL_EN:
- Defined: after a retire in WAIT_ARRIVE, enter DWELL for DWELL_CYCLES cycles, then SELECT. busy=1 during DWELL; calls are still captured.
- Undefined: no DWELL state; WAIT_ARRIVE retire goes directly to IDLE.

Decomposition:
- elevator_pkg: FLOOR_W, NUM_FLOORS, dispatcher state encoding, DIR_UP/DIR_DN constants.
- Sub-module elevator_scan_select: combinational; pending, current_floor, dir_up in; target_valid, target_floor, next_dir out.

Test Plan:
- Reset, then call floor 5 at floor 0 -> req_floor=5 two cycles later, dir_up=1. On controller arrival at 5 -> served pulse, served_floor=5, pending=0, busy=0.
- Call floor 2 while current_floor=2 and idle -> no req_floor change, served pulse with served_floor=2, pending bit cleared, no controller motion.
- At floor 3 heading to 6 (dir_up=1), inject calls 1 and 7 -> service order 6, 7, 1; dir_up drops to 0 when 1 is issued.
- Controller stops at 4 with req_floor=3 (overshoot) -> pending[3] kept, SELECT reissues req_floor=3, dir_up=0.
- Reset asserted in WAIT_ARRIVE with pending=8'b1010_0000 -> next cycle pending=0, req_floor=0, IDLE, no served pulse.
- With ELEV_DOOR_DWELL_EN, two calls 2 and 4 -> after serving 2, busy stays 1 for DWELL_CYCLES=4 before req_floor=4.
